// File: rtl/uart_note_parser_if.sv
// Byte-in / note-out bundle of uart_note_parser. The master side feeds bytes and consumes notes.
// The slave side is the parser itself.
interface uart_note_parser_if #(
  parameter int FIFO_DEPTH = 16
) ();
  logic [7:0]                  rx_data;
  logic                        rx_done;
  logic                        note_ready;
  logic                        ovf_clr;
  logic                        note_valid;
  logic [5:0]                  note_code;
  logic [7:0]                  note_dur;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        frame_err;
  logic                        overflow;

  modport master (
    output rx_data, rx_done, note_ready, ovf_clr,
    input  note_valid, note_code, note_dur, fifo_count, frame_err, overflow
  );

  modport slave (
    input  rx_data, rx_done, note_ready, ovf_clr,
    output note_valid, note_code, note_dur, fifo_count, frame_err, overflow
  );
endinterface

// File: rtl/uart_note_parser.sv
// Parses 4-byte note frames (AA, NOTE, DUR, NOTE^DUR) into a show-ahead note FIFO.
// Define UART_NOTE_TIMEOUT_EN to abandon half-received frames after TIMEOUT_CYCLES idle cycles.
module uart_note_parser #(
  parameter int FIFO_DEPTH     = 16,
  parameter int MAX_NOTE       = 36,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  uart_note_parser_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_NOTE, GOT_DUR} state_t;

  state_t      state;
  state_t      eff_state;
  logic [7:0]  note_q;
  logic [7:0]  dur_q;
  logic [13:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic timeout_hit;
  logic frame_ok;
  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic ovf_set;

`ifdef UART_NOTE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      tmo_cnt <= '0;
    else if (state == IDLE || bus.rx_done || timeout_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte landing on the timeout cycle is parsed as if the frame had already been abandoned.
  assign eff_state = timeout_hit ? IDLE : state;
  assign frame_ok  = (bus.rx_data == (note_q ^ dur_q)) &&
                     ({24'd0, note_q} <= 32'(MAX_NOTE));
  assign push_req  = bus.rx_done && (eff_state == GOT_DUR) && frame_ok;
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = bus.note_ready && (count != '0);
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      note_q        <= '0;
      dur_q         <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= timeout_hit;
      if (bus.rx_done) begin
        case (eff_state)
          IDLE:     state <= (bus.rx_data == 8'hAA) ? GOT_HDR : IDLE;
          GOT_HDR: begin
            note_q <= bus.rx_data;
            state  <= GOT_NOTE;
          end
          GOT_NOTE: begin
            dur_q <= bus.rx_data;
            state <= GOT_DUR;
          end
          GOT_DUR: begin
            state <= IDLE;
            if (!frame_ok)
              bus.frame_err <= 1'b1;
          end
          default:  state <= IDLE;
        endcase
      end else if (timeout_hit) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {note_q[5:0], dur_q};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh overflow outranks a clear requested in the same cycle.
      if (ovf_set)
        bus.overflow <= 1'b1;
      else if (bus.ovf_clr)
        bus.overflow <= 1'b0;
    end
  end

  assign bus.note_valid = (count != '0);
  assign bus.note_code  = mem[rd_ptr][13:8];
  assign bus.note_dur   = mem[rd_ptr][7:0];
  assign bus.fifo_count = count;
endmodule

// File: doc/uart_note_parser.md
Name: uart_note_parser

Overview:
- Downstream consumer of the UART receive path. Takes each received byte (rx_data plus a one-cycle rx_done strobe) and parses fixed 4-byte note frames.
- Validated note events are buffered in a show-ahead FIFO for the note player / tone generator.
- Malformed frames are dropped and flagged, so a noisy serial link never produces a wrong tone.

Parameters:
- FIFO_DEPTH, 16, number of note entries buffered; must be a power of 2, at least 2.
- MAX_NOTE, 36, highest legal note code; 0 means rest.
- TIMEOUT_CYCLES, 2_000_000, inter-byte timeout in sys_clk cycles; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only when rx_done=1.
- rx_done  in  1  one-cycle strobe, one per received byte.
- note_ready  in  1  consumer pops the head entry when note_valid=1 and note_ready=1.
- ovf_clr  in  1  synchronous clear of the overflow flag.
- note_valid  out  1  FIFO non-empty.
- note_code  out  6  head entry note code.
- note_dur  out  8  head entry duration, in units of 10 ms.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  out  1  one-cycle pulse per discarded frame.
- overflow  out  1  sticky; set when a good frame is dropped because the FIFO is full.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (sys_clk, sys_rst_n).
  - Reset clears the parser to IDLE and empties the FIFO.
  - After reset: note_valid=0, note_code=0, note_dur=0, fifo_count=0, frame_err=0, overflow=0.
  - Reset asserted mid-frame or mid-pop discards everything.
- Frame format: 0xAA, NOTE, DUR, CHK, where CHK = NOTE ^ DUR.
- Parser FSM; states advance only on cycles with rx_done=1:
  - IDLE: byte 0xAA -> GOT_HDR; any other byte is ignored, with no error.
  - GOT_HDR: latch NOTE -> GOT_NOTE. A 0xAA byte here is treated as data (no re-sync).
  - GOT_NOTE: latch DUR -> GOT_DUR.
  - GOT_DUR: -> IDLE in all cases.
    - If CHK matches and NOTE <= MAX_NOTE: push {NOTE[5:0], DUR}.
    - Otherwise: pulse frame_err for one cycle, no push.
- Push timing: the push happens on the same clock edge that samples the CHK byte, so note_valid rises the next cycle. Parser latency is 1 cycle after the last byte.
- Push into a full FIFO:
  - No pop that cycle: frame dropped, overflow set to 1, frame_err stays 0.
  - Pop in the same cycle: both push and pop succeed, fifo_count unchanged.
- Pop with an empty FIFO: ignored, fifo_count stays 0.
- Simultaneous push and pop when not full or empty: fifo_count unchanged, head advances.
- Outputs are show-ahead: note_code and note_dur always present the head entry. When empty they hold their last value and are don't-care.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges from 0 to FIFO_DEPTH.
- overflow: cleared by ovf_clr=1. If ovf_clr and a new overflow occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_NOTE_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is not in IDLE, and clears on every rx_done.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and frame_err pulses once.
  - An rx_done arriving in the same cycle as the timeout is processed as if the FSM were already in IDLE.
- Undefined: no counter; the parser waits indefinitely mid-frame.

Test Plan:
1. Bytes AA,0C,32,3E with note_ready=0 -> note_valid=1 one cycle after the last rx_done; note_code=12, note_dur=50, fifo_count=1, frame_err never pulses.
2. Bytes AA,0C,32,3F (bad CHK), then AA,30,01,31 (note 48 > MAX_NOTE) -> two single-cycle frame_err pulses, fifo_count=0, note_valid=0.
3. Leading garbage 55,00,AA then a valid frame AA,05,0A,0F, where the first AA is followed by 05… -> exactly one entry (note 5, duration 10), no frame_err from the garbage.
4. 17 valid frames with note_ready=0 -> fifo_count=16 and overflow=1. Pulse ovf_clr -> overflow=0. The FIFO still holds the first 16 entries, in order.
5. FIFO full, and note_ready=1 in the same cycle as the 17th CHK byte -> fifo_count stays 16, overflow=0. Popping all entries gives frames 2..17 in order.
6. With UART_NOTE_TIMEOUT_EN and TIMEOUT_CYCLES=100: send AA,0C, then idle for 100 cycles -> one frame_err pulse and FSM back in IDLE. A subsequent valid frame is accepted normally.
